// File: rtl/btn_pkg.sv
// Shared types and default parameters for the push-button conditioner.
package btn_pkg;

    // Auto-repeat phase of one channel.
    typedef enum logic [1:0] {
        REP_IDLE,
        REP_DELAY,
        REP_PERIOD
    } rep_phase_t;

    localparam int DEF_N_CH            = 21;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 8;
    localparam int DEF_REPEAT_PERIOD   = 4;

    // Largest of three values; sizes the shared counter width.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, tick-based debounce, edge pulses and auto-repeat.
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic nrst,
    input  logic tick,
    input  logic async_in,
    input  logic rep_en,
    output logic level,
    output logic pos_edge,
    output logic neg_edge,
    output logic repeat_pulse
);

    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_bit;
    logic [CW-1:0]          db_cnt_reg;
    logic                   level_reg;
    logic                   pos_reg;
    logic                   neg_reg;
    logic                   differ;
    logic                   at_limit;
    logic                   flip;
    logic                   rise;
    logic                   fall;

    // Synchroniser chain runs every clock, independent of tick.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) sync_reg <= '0;
        else       sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
    end

    assign sync_bit = sync_reg[SYNC_STAGES-1];
    assign differ   = (sync_bit != level_reg);
    assign at_limit = (db_cnt_reg == CW'(DEBOUNCE_CYCLES - 1));
    assign flip     = tick && differ && at_limit;
    assign rise     = flip && sync_bit;
    assign fall     = flip && !sync_bit;

    // Debounce counter, level register and registered edge pulses.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            db_cnt_reg <= '0;
            level_reg  <= 1'b0;
            pos_reg    <= 1'b0;
            neg_reg    <= 1'b0;
        end else begin
            pos_reg <= rise;
            neg_reg <= fall;
            if (tick) begin
                if (differ && !at_limit) db_cnt_reg <= db_cnt_reg + CW'(1);
                else                     db_cnt_reg <= '0;
                if (flip) level_reg <= sync_bit;
            end
        end
    end

    assign level    = level_reg;
    assign pos_edge = pos_reg;
    assign neg_edge = neg_reg;

    generate
        if (REPEAT_DELAY > 0) begin : g_repeat
            rep_phase_t    phase_reg, phase_next;
            logic [CW-1:0] rcnt_reg, rcnt_next;
            logic          rep_reg, pulse_next;

            // Repeat phase/counter state; pulse is registered so it lands with the phase update.
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    phase_reg <= REP_IDLE;
                    rcnt_reg  <= '0;
                    rep_reg   <= 1'b0;
                end else begin
                    phase_reg <= phase_next;
                    rcnt_reg  <= rcnt_next;
                    rep_reg   <= pulse_next;
                end
            end

            // Next phase: a falling level or disabled repeat wins over any pending pulse.
            always_comb begin
                phase_next = phase_reg;
                rcnt_next  = rcnt_reg;
                pulse_next = 1'b0;
                if (!rep_en || fall) begin
                    phase_next = REP_IDLE;
                    rcnt_next  = '0;
                end else if (tick) begin
                    case (phase_reg)
                        REP_IDLE: begin
                            // Entry on the press itself, or on re-enable while already held.
                            if (rise || level_reg) begin
                                phase_next = REP_DELAY;
                                rcnt_next  = '0;
                            end
                        end
                        REP_DELAY: begin
                            if (rcnt_reg == CW'(REPEAT_DELAY - 1)) begin
                                pulse_next = 1'b1;
                                phase_next = REP_PERIOD;
                                rcnt_next  = '0;
                            end else begin
                                rcnt_next = rcnt_reg + CW'(1);
                            end
                        end
                        REP_PERIOD: begin
                            if (rcnt_reg == CW'(REPEAT_PERIOD - 1)) begin
                                pulse_next = 1'b1;
                                rcnt_next  = '0;
                            end else begin
                                rcnt_next = rcnt_reg + CW'(1);
                            end
                        end
                        default: begin
                            phase_next = REP_IDLE;
                            rcnt_next  = '0;
                        end
                    endcase
                end
            end

            assign repeat_pulse = rep_reg;
        end else begin : g_no_repeat
            assign repeat_pulse = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button front end: one independent btn_channel per input pin.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            tick,
    input  logic [N_CH-1:0] async_in,
    input  logic [N_CH-1:0] rep_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pos_edge,
    output logic [N_CH-1:0] neg_edge,
    output logic [N_CH-1:0] repeat_pulse
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            btn_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD)
            ) u_ch (
                .clk         (clk),
                .nrst        (nrst),
                .tick        (tick),
                .async_in    (async_in[gi]),
                .rep_en      (rep_en[gi]),
                .level       (level[gi]),
                .pos_edge    (pos_edge[gi]),
                .neg_edge    (neg_edge[gi]),
                .repeat_pulse(repeat_pulse[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (default parameters).
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int N = DEF_N_CH;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         tick = 1'b1;
    logic [N-1:0] async_in = '0;
    logic [N-1:0] rep_en = '0;
    logic [N-1:0] level, pos_edge, neg_edge, repeat_pulse;

    button_conditioner dut (
        .clk         (clk),
        .nrst        (nrst),
        .tick        (tick),
        .async_in    (async_in),
        .rep_en      (rep_en),
        .level       (level),
        .pos_edge    (pos_edge),
        .neg_edge    (neg_edge),
        .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, gcyc equals the number of posedges so far.
    int gcyc = 0;
    always @(posedge clk) gcyc++;

    typedef struct {
        int cyc;
        int ch;
        int kind;   // 0 pos_edge, 1 neg_edge, 2 repeat_pulse
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  errors = 0;
    int  checks = 0;

    // Observed pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (nrst) begin
            for (int c = 0; c < N; c++) begin
                if (pos_edge[c])     obs_q.push_back('{gcyc, c, 0});
                if (neg_edge[c])     obs_q.push_back('{gcyc, c, 1});
                if (repeat_pulse[c]) obs_q.push_back('{gcyc, c, 2});
            end
        end
    end

    task automatic expect_ev(input int cyc, input int ch, input int kind);
        exp_q.push_back('{cyc, ch, kind});
    endtask

    task automatic check_level(input string nm, input int ch, input logic expv);
        checks++;
        if (level[ch] !== expv) begin
            errors++;
            $display("FAIL %s: level[%0d]=%b expected %b at cycle %0d", nm, ch, level[ch], expv, gcyc);
        end else begin
            $display("ok   %s: level[%0d]=%b at cycle %0d", nm, ch, level[ch], gcyc);
        end
    endtask

    task automatic check_all_zero(input string nm);
        checks++;
        if ({level, pos_edge, neg_edge, repeat_pulse} !== '0) begin
            errors++;
            $display("FAIL %s: level=%h pos=%h neg=%h rep=%h expected all 0", nm, level, pos_edge, neg_edge, repeat_pulse);
        end else begin
            $display("ok   %s: all outputs 0", nm);
        end
    endtask

    // Match every expected pulse against the observed list; leftovers are unexpected pulses.
    task automatic check_segment(input string nm);
        int idx;
        foreach (exp_q[e]) begin
            checks++;
            idx = -1;
            foreach (obs_q[o]) begin
                if (idx < 0 && obs_q[o].cyc == exp_q[e].cyc && obs_q[o].ch == exp_q[e].ch
                    && obs_q[o].kind == exp_q[e].kind) idx = o;
            end
            if (idx < 0) begin
                errors++;
                $display("FAIL %s: pulse kind=%0d ch=%0d missing, expected at cycle %0d", nm, exp_q[e].kind, exp_q[e].ch, exp_q[e].cyc);
            end else begin
                $display("ok   %s: pulse kind=%0d ch=%0d at cycle %0d", nm, exp_q[e].kind, exp_q[e].ch, exp_q[e].cyc);
                obs_q.delete(idx);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d unexpected pulses, first kind=%0d ch=%0d cycle %0d, expected none", nm, obs_q.size(), obs_q[0].kind, obs_q[0].ch, obs_q[0].cyc);
        end else begin
            $display("ok   %s: no unexpected pulses", nm);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    typedef struct {
        string name;
        int    ch;
        int    hold;   // clocks the input stays high
        bit    rep;
        int    pos;    // expected pos_edge cycle, -1 for none
        int    neg;    // expected neg_edge cycle, -1 for none
        int    r0, r1, r2, r3;  // expected repeat cycles, -1 for none
    } vec_t;

    vec_t vt[6];

    initial begin
        int base;
        int rel;
        vt[0] = '{"clean",        0, 40, 1'b0,  6, 46, -1, -1, -1, -1};
        vt[1] = '{"bounce3",      3,  3, 1'b0, -1, -1, -1, -1, -1, -1};
        vt[2] = '{"glitch1",      4,  1, 1'b0, -1, -1, -1, -1, -1, -1};
        vt[3] = '{"min_press",   10,  4, 1'b0,  6, 10, -1, -1, -1, -1};
        vt[4] = '{"repeat",       5, 24, 1'b1,  6, 30, 14, 18, 22, 26};
        vt[5] = '{"rep_disabled", 6, 24, 1'b0,  6, 30, -1, -1, -1, -1};

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single-channel presses (cycle k = k-th posedge after the change)
        foreach (vt[v]) begin
            rep_en[vt[v].ch] = vt[v].rep;
            base = gcyc;
            async_in[vt[v].ch] = 1'b1;
            if (vt[v].pos >= 0) expect_ev(base + vt[v].pos, vt[v].ch, 0);
            if (vt[v].neg >= 0) expect_ev(base + vt[v].neg, vt[v].ch, 1);
            if (vt[v].r0 >= 0)  expect_ev(base + vt[v].r0, vt[v].ch, 2);
            if (vt[v].r1 >= 0)  expect_ev(base + vt[v].r1, vt[v].ch, 2);
            if (vt[v].r2 >= 0)  expect_ev(base + vt[v].r2, vt[v].ch, 2);
            if (vt[v].r3 >= 0)  expect_ev(base + vt[v].r3, vt[v].ch, 2);
            for (int k = 1; k <= vt[v].hold + 25; k++) begin
                @(negedge clk);
                rel = gcyc - base;
                if (rel == vt[v].hold) async_in[vt[v].ch] = 1'b0;
                if (vt[v].pos >= 0 && rel == vt[v].pos - 1) check_level({vt[v].name, "_pre"}, vt[v].ch, 1'b0);
                if (vt[v].pos >= 0 && rel == vt[v].pos)     check_level({vt[v].name, "_up"}, vt[v].ch, 1'b1);
                if (vt[v].neg >= 0 && rel == vt[v].neg)     check_level({vt[v].name, "_down"}, vt[v].ch, 1'b0);
            end
            if (vt[v].pos < 0) check_level({vt[v].name, "_end"}, vt[v].ch, 1'b0);
            check_segment(vt[v].name);
            rep_en[vt[v].ch] = 1'b0;
        end

        // Same-cycle rise on ch1 and fall on ch2
        base = gcyc;
        async_in[2] = 1'b1;
        expect_ev(base + 6, 2, 0);
        repeat (10) @(negedge clk);
        check_level("ch2_held", 2, 1'b1);
        base = gcyc;
        async_in[1] = 1'b1;
        async_in[2] = 1'b0;
        expect_ev(base + 6, 1, 0);
        expect_ev(base + 6, 2, 1);
        repeat (12) @(negedge clk);
        base = gcyc;
        async_in[1] = 1'b0;
        expect_ev(base + 6, 1, 1);
        repeat (12) @(negedge clk);
        check_segment("same_cycle");

        // Slow tick: tick on every 4th clk; debounce sees ticks at 4,8,12,16
        base = gcyc;
        async_in[7] = 1'b1;
        expect_ev(base + 16, 7, 0);
        for (int k = 1; k <= 20; k++) begin
            tick = (k % 4 == 0);
            @(negedge clk);
            if (k == 15) check_level("slow_tick_pre", 7, 1'b0);
            if (k == 16) check_level("slow_tick_up", 7, 1'b1);
        end
        // Release: two counted ticks, a long freeze, then two more ticks flip the level
        base = gcyc;
        async_in[7] = 1'b0;
        expect_ev(base + 26, 7, 1);
        for (int k = 1; k <= 30; k++) begin
            tick = (k <= 4 || k >= 25);
            @(negedge clk);
            if (k == 24) check_level("freeze_hold", 7, 1'b1);
            if (k == 25) check_level("freeze_resume", 7, 1'b1);
            if (k == 26) check_level("freeze_down", 7, 1'b0);
        end
        tick = 1'b1;
        check_segment("slow_tick");

        // Re-enable repeat mid-hold, then disable it
        base = gcyc;
        async_in[12] = 1'b1;
        expect_ev(base + 6, 12, 0);
        repeat (10) @(negedge clk);
        base = gcyc;
        rep_en[12] = 1'b1;
        expect_ev(base + 9, 12, 2);
        expect_ev(base + 13, 12, 2);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (gcyc - base == 14) rep_en[12] = 1'b0;
        end
        base = gcyc;
        async_in[12] = 1'b0;
        expect_ev(base + 6, 12, 1);
        repeat (10) @(negedge clk);
        check_segment("rep_reenable");

        // Reset mid-debounce (ch0) and with a held level (ch9)
        base = gcyc;
        async_in[9] = 1'b1;
        expect_ev(base + 6, 9, 0);
        repeat (10) @(negedge clk);
        async_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        check_segment("pre_reset");
        #2 nrst = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        nrst = 1'b1;
        base = gcyc;
        expect_ev(base + 6, 0, 0);
        expect_ev(base + 6, 9, 0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 5) check_level("post_reset_pre", 0, 1'b0);
            if (k == 6) check_level("post_reset_up", 0, 1'b1);
            if (k == 6) check_level("post_reset_ch9", 9, 1'b1);
        end
        check_segment("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
